// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Main data memory model behind the D-cache: DEPTH blocks of WIDTH bits.
//   Accepts one block read or block write per request. Completion is
//   signalled by a one-cycle ack that appears LATENCY cycles after the
//   accepting clock edge. A write is committed at the edge that ends its
//   ack cycle, so the data shown during a write ack is the old content.
//
//   Optional feature macro: DMEM_OOB_GUARD_EN
//     defined   : address bits above the block index must be zero. Other
//                 requests still take LATENCY cycles and ack, but writes
//                 are dropped and data_o reads as zero.
//     undefined : upper address bits are ignored and the index wraps.
//
// Ports
//   clk_i     in   1      clock, all state on the rising edge
//   rst_i     in   1      asynchronous active-low reset
//   addr_i    in   32     byte address of the block (low ADDR_LSB bits ignored)
//   data_i    in   WIDTH  write block data
//   enable_i  in   1      request valid (sampled only while idle)
//   write_i   in   1      1 = write block, 0 = read block
//   ack_o     out  1      request complete, high for exactly one cycle
//   data_o    out  WIDTH  block content while ack_o=1, zero otherwise
//
//   The storage array is named memory so a bench can reach it by hierarchy.
//   It is not cleared by reset.
// -----------------------------------------------------------------------------
module data_memory #(
   parameter int DEPTH    = 512,
   parameter int WIDTH    = 256,
   parameter int LATENCY  = 10,
   parameter int ADDR_LSB = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      addr_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             enable_i,
   input  logic             write_i,
   output logic             ack_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [IDX_W-1:0]   idx_reg;
   logic [WIDTH-1:0]   wdata_reg;
   logic               write_reg;
   logic               oob_reg;
   logic [WIDTH-1:0]   rdata_reg;
   logic               accept;
   logic               commit;
   logic               req_oob;

   logic [WIDTH-1:0]   memory [0:DEPTH-1];

   // ------------------------------------------------------------------
   // Out-of-bounds detection for the incoming request
   // ------------------------------------------------------------------
`ifdef DMEM_OOB_GUARD_EN
   logic addr_unused;
   assign req_oob     = (addr_i[31:ADDR_LSB+IDX_W] != '0);
   assign addr_unused = ^addr_i[ADDR_LSB-1:0];
`else
   logic addr_unused;
   assign req_oob     = 1'b0;
   assign addr_unused = ^{addr_i[31:ADDR_LSB+IDX_W], addr_i[ADDR_LSB-1:0]};
`endif

   // ------------------------------------------------------------------
   // Control FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         wdata_reg <= '0;
         write_reg <= 1'b0;
         oob_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         // Request fields are captured once; inputs are don't-care afterwards.
         if (accept) begin
            idx_reg   <= addr_i[ADDR_LSB +: IDX_W];
            wdata_reg <= data_i;
            write_reg <= write_i;
            oob_reg   <= req_oob;
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      ack_o      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable_i) begin
               accept     = 1'b1;
               state_next = BUSY;
               cnt_next   = '0;
            end
         end
         BUSY: begin
            // Requests arriving while busy are simply not looked at.
            if (cnt_reg == CNT_LAST) begin
               ack_o      = 1'b1;
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Storage. The read is registered every cycle from the latched index;
   // since LATENCY >= 2 at least one busy edge precedes the ack cycle, so
   // rdata_reg already holds the addressed block when ack_o rises. That
   // read happens before this request's own write commits, which is why a
   // write ack shows the previous content.
   // ------------------------------------------------------------------
   assign commit = ack_o && write_reg && !oob_reg;

   always_ff @(posedge clk_i) begin
      if (commit) begin
         memory[idx_reg] <= wdata_reg;
      end
      rdata_reg <= memory[idx_reg];
   end

   assign data_o = (ack_o && !oob_reg) ? rdata_reg : '0;

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//   Self-checking bench for data_memory. A behavioural model (an array of
//   blocks plus address arithmetic) predicts every ack time and every
//   returned block. Directed cases cover reset during a write, the preload
//   pattern, the 0x220 write, requests ignored while busy, back-to-back
//   reads and index wrap; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_data_memory;

   localparam int DEPTH    = 512;
   localparam int WIDTH    = 256;
   localparam int LATENCY  = 10;
   localparam int ADDR_LSB = 5;

   logic             clk;
   logic             rst_n;
   logic [31:0]      addr_i;
   logic [WIDTH-1:0] data_i;
   logic             enable_i;
   logic             write_i;
   logic             ack_o;
   logic [WIDTH-1:0] data_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [WIDTH-1:0] model [0:DEPTH-1];
   bit               valid [0:DEPTH-1];

   data_memory #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY),
      .ADDR_LSB(ADDR_LSB)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .enable_i(enable_i),
      .write_i (write_i),
      .ack_o   (ack_o),
      .data_o  (data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_block();
      logic [WIDTH-1:0] v;
      for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic int block_index(input logic [31:0] addr);
      return int'((addr >> ADDR_LSB) % DEPTH);
   endfunction

   function automatic bit out_of_bounds(input logic [31:0] addr);
`ifdef DMEM_OOB_GUARD_EN
      return (addr / (DEPTH * (1 << ADDR_LSB))) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // One request. Called at a negedge. after_ack=1 means the call is made
   // during the previous request's ack cycle, so acceptance (and the ack)
   // come one cycle later. keep_en leaves enable_i high; noise drives a
   // competing write to another block while busy; chain skips the
   // post-ack idle check so a following request can start at once.
   task automatic request(input string tag, input logic [31:0] addr,
                          input logic [WIDTH-1:0] data, input logic wr,
                          input bit after_ack, input bit keep_en,
                          input bit noise, input bit chain);
      int               idx;
      bit               oob;
      int               accept_k;
      int               exp_k;
      int               ack_k;
      int               acks;
      int               bad;
      logic [WIDTH-1:0] got;
      logic [WIDTH-1:0] exp_data;

      idx      = block_index(addr);
      oob      = out_of_bounds(addr);
      exp_data = oob ? '0 : model[idx];
      accept_k = after_ack ? 2 : 1;
      exp_k    = LATENCY + accept_k - 1;
      ack_k    = 0;
      acks     = 0;
      bad      = 0;
      got      = '0;

      addr_i   = addr;
      data_i   = data;
      write_i  = wr;
      enable_i = 1'b1;
      for (int k = 1; k <= exp_k; k++) begin
         @(negedge clk);
         if (ack_o) begin
            acks++;
            if (ack_k == 0) begin
               ack_k = k;
               got   = data_o;
            end
         end else if (data_o != '0) begin
            bad++;
         end
         if (!keep_en && k >= accept_k) enable_i = 1'b0;
         if (noise && k == accept_k + 2) begin
            enable_i = 1'b1;
            addr_i   = addr ^ 32'h0000_0100;
            write_i  = 1'b1;
            data_i   = ~data;
         end
         if (noise && k == accept_k + 3) enable_i = 1'b0;
      end

      check({tag, "/ack_cycle"}, WIDTH'(ack_k), WIDTH'(exp_k));
      check({tag, "/ack_count"}, WIDTH'(acks), WIDTH'(1));
      check({tag, "/data_o_idle"}, WIDTH'(bad), '0);
      if (oob || valid[idx]) check({tag, "/data_o"}, got, exp_data);

      if (!chain) begin
         @(negedge clk);
         check({tag, "/post_ack"}, WIDTH'(ack_o), '0);
         check({tag, "/post_data"}, data_o, '0);
      end

      if (wr && !oob) begin
         model[idx] = data;
         valid[idx] = 1'b1;
      end
      $display("txn %s %s addr=%08h idx=%0d oob=%0d ack@%0d data=%0h",
               tag, wr ? "WR" : "RD", addr, idx, oob, ack_k, got[31:0]);
   endtask

   initial begin
      logic [WIDTH-1:0] pat;
      logic [WIDTH-1:0] d;
      logic [31:0]      a;
      int               acks;
      int               idx;
      int               hi;

      for (int i = 0; i < DEPTH; i++) valid[i] = 1'b0;
      rst_n    = 1'b0;
      addr_i   = '0;
      data_i   = '0;
      enable_i = 1'b0;
      write_i  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset/ack", WIDTH'(ack_o), '0);
      check("reset/data", data_o, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Give the first 64 blocks known contents
      for (int i = 0; i < 64; i++)
         request("init", 32'(i << ADDR_LSB), rand_block(), 1'b1, 0, 0, 0, 0);

      // Reset while a write to 0x40 is at cnt=4: never acks, never commits
      addr_i   = 32'h40;
      data_i   = ~model[2];
      write_i  = 1'b1;
      enable_i = 1'b1;
      @(negedge clk);
      enable_i = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst/ack", WIDTH'(ack_o), '0);
      check("midrst/data", data_o, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      acks  = 0;
      repeat (LATENCY + 3) begin
         @(negedge clk);
         if (ack_o) acks++;
      end
      check("midrst/no_ack", WIDTH'(acks), '0);
      request("midrst_rd", 32'h40, '0, 1'b0, 0, 0, 0, 0);

      // Preload pattern 0000_1111_..._FFFF at block 0, read back
      for (int i = 0; i < 16; i++) pat[i*16 +: 16] = {4{4'(15 - i)}};
      request("preload", 32'h0, pat, 1'b1, 0, 0, 0, 0);
      request("rd_0x0", 32'h0, '0, 1'b0, 0, 0, 0, 0);

      // All-A5 write to 0x220 (block 17), read back
      request("wr_0x220", 32'h220, {(WIDTH/8){8'hA5}}, 1'b1, 0, 0, 0, 0);
      request("rd_0x220", 32'h220, '0, 1'b0, 0, 0, 0, 0);

      // Competing write while busy must be ignored
      request("busy_pulse", 32'h0A0, '0, 1'b0, 0, 0, 1, 0);
      request("busy_victim", 32'h0A0 ^ 32'h100, '0, 1'b0, 0, 0, 0, 0);

      // Back-to-back reads with enable_i held: second ack 11 cycles later
      request("b2b_0x200", 32'h200, '0, 1'b0, 0, 1, 0, 1);
      request("b2b_0x400", 32'h400, '0, 1'b0, 1, 0, 0, 0);

      // Index wrap / out-of-bounds
      request("wrap_rd", 32'h4000, '0, 1'b0, 0, 0, 0, 0);
      request("wrap_wr", 32'h4000, rand_block(), 1'b1, 0, 0, 0, 0);
      request("wrap_chk", 32'h0, '0, 1'b0, 0, 0, 0, 0);

      // Randomized traffic over the initialised blocks
      for (int n = 0; n < 40; n++) begin
         idx = $urandom_range(0, 63);
         hi  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32'h3FFFF)) : 0;
         a   = (32'(hi) << (ADDR_LSB + 9)) | (32'(idx) << ADDR_LSB)
               | 32'($urandom_range(0, 31));
         d   = rand_block();
         request("rand", a, d, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
